pipe_ctrl_tracker: RTL and testbench

- Carries decoded control bits and the destination register from ID through the EXE, MEM and WB pipeline registers.
- Feeds the EXE/MEM stage status (edestReg, em2reg, ewreg, mdestReg, mm2reg, mwreg) back to the decode-stage control/forwarding logic.
- Detects load-use hazards and inserts one bubble per hazard.
- Freezes the back end while data memory is not ready.
- Sits between the ID-stage control unit and the EXE/MEM/WB datapath registers.

---
 rtl/pipe_ctrl_pkg.sv | 20 ++
 rtl/pipe_ctrl_tracker_if.sv | 65 ++++++
 rtl/pipe_stage_reg.sv | 29 ++
 rtl/pipe_ctrl_tracker.sv | 110 +++++++++++
 tb/tb_pipe_ctrl_tracker.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline control tracker.
// Optional statistics counters are enabled with PIPE_CTRL_STATS_EN.
package pipe_ctrl_pkg;

    localparam int REG_AW = 5;
    localparam int ALUC_W = 4;
    localparam int STAT_W = 16;

    typedef struct packed {
        logic              wreg;
        logic              m2reg;
        logic              wmem;
        logic [ALUC_W-1:0] aluc;
        logic              aluimm;
        logic [REG_AW-1:0] dest;
    } stage_ctrl_t;

    localparam stage_ctrl_t BUBBLE = '0;

endpackage

// File: rtl/pipe_ctrl_tracker_if.sv
// Decode-side control bus of the pipeline control tracker.
// Statistics signals exist only when PIPE_CTRL_STATS_EN is defined.
interface pipe_ctrl_tracker_if;
    import pipe_ctrl_pkg::*;

    logic              d_valid;
    logic              d_wreg;
    logic              d_m2reg;
    logic              d_wmem;
    logic [ALUC_W-1:0] d_aluc;
    logic              d_aluimm;
    logic              d_regrt;
    logic [REG_AW-1:0] d_rs;
    logic [REG_AW-1:0] d_rt;
    logic [REG_AW-1:0] d_rd;
    logic              d_uses_rs;
    logic              d_uses_rt;
    logic              flush;
    logic              dmem_ready;

    logic              ewreg;
    logic              em2reg;
    logic              ewmem;
    logic [ALUC_W-1:0] ealuc;
    logic              ealuimm;
    logic [REG_AW-1:0] edestReg;
    logic              mwreg;
    logic              mm2reg;
    logic              mwmem;
    logic [REG_AW-1:0] mdestReg;
    logic              wwreg;
    logic              wm2reg;
    logic [REG_AW-1:0] wdestReg;
    logic              stall;
    logic              hold;
`ifdef PIPE_CTRL_STATS_EN
    logic [STAT_W-1:0] stall_cnt;
    logic [STAT_W-1:0] freeze_cnt;
`endif

    modport master (
        output d_valid, d_wreg, d_m2reg, d_wmem, d_aluc, d_aluimm,
        output d_regrt, d_rs, d_rt, d_rd, d_uses_rs, d_uses_rt,
        output flush, dmem_ready,
        input  ewreg, em2reg, ewmem, ealuc, ealuimm, edestReg,
        input  mwreg, mm2reg, mwmem, mdestReg,
        input  wwreg, wm2reg, wdestReg, stall, hold
`ifdef PIPE_CTRL_STATS_EN
        , input stall_cnt, freeze_cnt
`endif
    );

    modport slave (
        input  d_valid, d_wreg, d_m2reg, d_wmem, d_aluc, d_aluimm,
        input  d_regrt, d_rs, d_rt, d_rd, d_uses_rs, d_uses_rt,
        input  flush, dmem_ready,
        output ewreg, em2reg, ewmem, ealuc, ealuimm, edestReg,
        output mwreg, mm2reg, mwmem, mdestReg,
        output wwreg, wm2reg, wdestReg, stall, hold
`ifdef PIPE_CTRL_STATS_EN
        , output stall_cnt, freeze_cnt
`endif
    );

endinterface

// File: rtl/pipe_stage_reg.sv
// One pipeline control register with hold, load and bubble insertion.
// Reset and bubble both load the all-zero control word.
module pipe_stage_reg
    import pipe_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_bubble,
    input  stage_ctrl_t i_d,
    output stage_ctrl_t o_q
);

    stage_ctrl_t r_q;

    // Bubble beats load; neither asserted means hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= BUBBLE;
        end else if (i_bubble) begin
            r_q <= BUBBLE;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipe_ctrl_tracker.sv
// Carries decoded control through EXE/MEM/WB, detects load-use hazards.
// Define PIPE_CTRL_STATS_EN to add saturating stall/freeze counters.
module pipe_ctrl_tracker
    import pipe_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    pipe_ctrl_tracker_if.slave  bus
);

    stage_ctrl_t w_id;
    stage_ctrl_t w_e;
    stage_ctrl_t w_m;
    stage_ctrl_t w_w;
    logic        w_rs_hit;
    logic        w_rt_hit;
    logic        w_stall;
    logic        w_freeze;
    logic        w_e_bubble;

    // Pack the decoded instruction, picking rt or rd as destination.
    always_comb begin
        w_id        = BUBBLE;
        w_id.wreg   = bus.d_wreg;
        w_id.m2reg  = bus.d_m2reg;
        w_id.wmem   = bus.d_wmem;
        w_id.aluc   = bus.d_aluc;
        w_id.aluimm = bus.d_aluimm;
        w_id.dest   = bus.d_regrt ? bus.d_rt : bus.d_rd;
    end

    assign w_rs_hit = bus.d_uses_rs && (w_e.dest == bus.d_rs);
    assign w_rt_hit = bus.d_uses_rt && (w_e.dest == bus.d_rt);

    // A load still in EXE cannot forward; anything else can.
    assign w_stall = !rst && bus.d_valid && w_e.m2reg && w_e.wreg
                   && (w_e.dest != '0) && (w_rs_hit || w_rt_hit);

    assign w_freeze   = !bus.dmem_ready;
    assign w_e_bubble = !w_freeze
                      && (w_stall || bus.flush || !bus.d_valid);

    pipe_stage_reg u_e (
        .clk      (clk),
        .rst      (rst),
        .i_load   (!w_freeze),
        .i_bubble (w_e_bubble),
        .i_d      (w_id),
        .o_q      (w_e)
    );

    pipe_stage_reg u_m (
        .clk      (clk),
        .rst      (rst),
        .i_load   (!w_freeze),
        .i_bubble (1'b0),
        .i_d      (w_e),
        .o_q      (w_m)
    );

    // WB takes a bubble while frozen so a writeback is never repeated.
    pipe_stage_reg u_w (
        .clk      (clk),
        .rst      (rst),
        .i_load   (1'b1),
        .i_bubble (w_freeze),
        .i_d      (w_m),
        .o_q      (w_w)
    );

    assign bus.ewreg    = w_e.wreg;
    assign bus.em2reg   = w_e.m2reg;
    assign bus.ewmem    = w_e.wmem;
    assign bus.ealuc    = w_e.aluc;
    assign bus.ealuimm  = w_e.aluimm;
    assign bus.edestReg = w_e.dest;
    assign bus.mwreg    = w_m.wreg;
    assign bus.mm2reg   = w_m.m2reg;
    assign bus.mwmem    = w_m.wmem;
    assign bus.mdestReg = w_m.dest;
    assign bus.wwreg    = w_w.wreg;
    assign bus.wm2reg   = w_w.m2reg;
    assign bus.wdestReg = w_w.dest;
    assign bus.stall    = w_stall;
    assign bus.hold     = !rst && (w_stall || w_freeze);

`ifdef PIPE_CTRL_STATS_EN
    localparam logic [STAT_W-1:0] CNT_MAX = '1;

    logic [STAT_W-1:0] r_stall_cnt;
    logic [STAT_W-1:0] r_freeze_cnt;

    // Saturating counts of lost cycles by cause.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt  <= '0;
            r_freeze_cnt <= '0;
        end else begin
            if (w_stall && !w_freeze && r_stall_cnt != CNT_MAX)
                r_stall_cnt <= r_stall_cnt + STAT_W'(1);
            if (w_freeze && r_freeze_cnt != CNT_MAX)
                r_freeze_cnt <= r_freeze_cnt + STAT_W'(1);
        end
    end

    assign bus.stall_cnt  = r_stall_cnt;
    assign bus.freeze_cnt = r_freeze_cnt;
`endif

endmodule

// File: tb/tb_pipe_ctrl_tracker.sv
// Self-checking bench for pipe_ctrl_tracker: directed plus random stimulus.
// Counter checks are compiled in when PIPE_CTRL_STATS_EN is defined.
module tb_pipe_ctrl_tracker;

    logic clk;
    logic rst;

    pipe_ctrl_tracker_if bus ();

    pipe_ctrl_tracker dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: an in-flight instruction is a small record.
    typedef struct {
        bit       wr;
        bit       ld;
        bit       st;
        bit [3:0] op;
        bit       imm;
        bit [4:0] dst;
    } slot_t;

    slot_t ex, me, wb;
    int    m_stall_cnt;
    int    m_freeze_cnt;
    int    n_checks;
    int    n_fail;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic slot_t empty_slot();
        slot_t s;
        s = '{default: 0};
        return s;
    endfunction

    function automatic slot_t id_slot();
        slot_t s;
        s.wr  = bus.d_wreg;
        s.ld  = bus.d_m2reg;
        s.st  = bus.d_wmem;
        s.op  = bus.d_aluc;
        s.imm = bus.d_aluimm;
        s.dst = bus.d_regrt ? bus.d_rt : bus.d_rd;
        return s;
    endfunction

    // Load in EXE whose nonzero target is read by the ID instruction.
    function automatic bit exp_stall();
        bit hit;
        if (rst || !bus.d_valid) return 1'b0;
        if (!(ex.ld && ex.wr) || ex.dst == 0) return 1'b0;
        hit = (bus.d_uses_rs && ex.dst == bus.d_rs)
           || (bus.d_uses_rt && ex.dst == bus.d_rt);
        return hit;
    endfunction

    task automatic check_regs();
        chk("ewreg",    bus.ewreg,    ex.wr);
        chk("em2reg",   bus.em2reg,   ex.ld);
        chk("ewmem",    bus.ewmem,    ex.st);
        chk("ealuc",    bus.ealuc,    ex.op);
        chk("ealuimm",  bus.ealuimm,  ex.imm);
        chk("edestReg", bus.edestReg, ex.dst);
        chk("mwreg",    bus.mwreg,    me.wr);
        chk("mm2reg",   bus.mm2reg,   me.ld);
        chk("mwmem",    bus.mwmem,    me.st);
        chk("mdestReg", bus.mdestReg, me.dst);
        chk("wwreg",    bus.wwreg,    wb.wr);
        chk("wm2reg",   bus.wm2reg,   wb.ld);
        chk("wdestReg", bus.wdestReg, wb.dst);
`ifdef PIPE_CTRL_STATS_EN
        chk("stall_cnt",  bus.stall_cnt,  m_stall_cnt);
        chk("freeze_cnt", bus.freeze_cnt, m_freeze_cnt);
`endif
    endtask

    // One clock: check combinational outputs, advance model, check regs.
    task automatic cycle();
        bit es;
        bit frz;
        #1;
        es  = exp_stall();
        frz = !bus.dmem_ready;
        chk("stall", bus.stall, es);
        chk("hold",  bus.hold,  !rst && (es || frz));
        @(posedge clk);
        if (rst) begin
            ex = empty_slot();
            me = empty_slot();
            wb = empty_slot();
            m_stall_cnt  = 0;
            m_freeze_cnt = 0;
        end else if (frz) begin
            wb = empty_slot();
            if (m_freeze_cnt < 65535) m_freeze_cnt++;
        end else begin
            wb = me;
            me = ex;
            if (es || bus.flush || !bus.d_valid) ex = empty_slot();
            else                                 ex = id_slot();
            if (es && m_stall_cnt < 65535) m_stall_cnt++;
        end
        #1;
        check_regs();
        @(negedge clk);
    endtask

    task automatic rand_inputs();
        bus.d_valid   = ($urandom_range(0, 3) != 0);
        bus.d_wreg    = ($urandom_range(0, 3) != 0);
        bus.d_m2reg   = ($urandom_range(0, 4) < 2);
        bus.d_wmem    = ($urandom_range(0, 4) == 0);
        bus.d_aluc    = 4'($urandom);
        bus.d_aluimm  = 1'($urandom);
        bus.d_regrt   = 1'($urandom);
        bus.d_rs      = 5'($urandom_range(0, 3));
        bus.d_rt      = 5'($urandom_range(0, 3));
        bus.d_rd      = 5'($urandom_range(0, 3));
        bus.d_uses_rs = 1'($urandom);
        bus.d_uses_rt = 1'($urandom);
        bus.flush     = ($urandom_range(0, 9) == 0);
        bus.dmem_ready = ($urandom_range(0, 4) != 0);
    endtask

    task automatic set_idle();
        bus.d_valid = 0; bus.d_wreg = 0; bus.d_m2reg = 0;
        bus.d_wmem = 0; bus.d_aluc = 0; bus.d_aluimm = 0;
        bus.d_regrt = 0; bus.d_rs = 0; bus.d_rt = 0; bus.d_rd = 0;
        bus.d_uses_rs = 0; bus.d_uses_rt = 0;
        bus.flush = 0; bus.dmem_ready = 1;
    endtask

    // Register-type op: rd = rs op rt.
    task automatic set_rtype(input logic [4:0] rs, input logic [4:0] rt,
                             input logic [4:0] rd);
        set_idle();
        bus.d_valid = 1; bus.d_wreg = 1; bus.d_aluc = 4'h2;
        bus.d_rs = rs; bus.d_rt = rt; bus.d_rd = rd;
        bus.d_uses_rs = 1; bus.d_uses_rt = 1;
    endtask

    // Load: rt = mem[rs + imm].
    task automatic set_load(input logic [4:0] rs, input logic [4:0] rt);
        set_idle();
        bus.d_valid = 1; bus.d_wreg = 1; bus.d_m2reg = 1;
        bus.d_aluimm = 1; bus.d_regrt = 1;
        bus.d_rs = rs; bus.d_rt = rt; bus.d_uses_rs = 1;
    endtask

    task automatic do_reset();
        rst = 1;
        repeat (2) begin
            rand_inputs();
            cycle();
        end
        rst = 0;
        set_idle();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        ex = empty_slot();
        me = empty_slot();
        wb = empty_slot();
        m_stall_cnt  = 0;
        m_freeze_cnt = 0;
        rst = 1;
        set_idle();
        @(negedge clk);

        // Reset with random inputs.
        do_reset();
        chk("rst_wdest", bus.wdestReg, 0);
        chk("rst_ewreg", bus.ewreg, 0);

        // ADD $3,$1,$2 then bubbles.
        set_rtype(5'd1, 5'd2, 5'd3);
        cycle();
        chk("add_edest", bus.edestReg, 3);
        set_idle();
        cycle();
        chk("add_mdest", bus.mdestReg, 3);
        cycle();
        chk("add_wdest", bus.wdestReg, 3);
        chk("add_wwreg", bus.wwreg, 1);

        // LW $5 then ADD $6,$5,$2: one stall cycle.
        do_reset();
        set_load(5'd1, 5'd5);
        cycle();
        set_rtype(5'd5, 5'd2, 5'd6);
        #1 chk("lu_stall", bus.stall, 1);
        cycle();
        chk("lu_bubble", bus.ewreg, 0);
        chk("lu_mdest", bus.mdestReg, 5);
        #1 chk("lu_release", bus.stall, 0);
        cycle();
        chk("lu_late", bus.edestReg, 6);
        chk("lu_late_wr", bus.ewreg, 1);
`ifdef PIPE_CTRL_STATS_EN
        chk("lu_stall_cnt", bus.stall_cnt, 1);
`endif

        // LW $0 then a reader of $0: never stalls.
        set_load(5'd1, 5'd0);
        cycle();
        set_rtype(5'd0, 5'd0, 5'd4);
        #1 chk("r0_stall", bus.stall, 0);
        cycle();
        chk("r0_edest", bus.edestReg, 4);

        // Freeze with LW $7 in MEM.
        do_reset();
        set_load(5'd2, 5'd7);
        cycle();
        set_idle();
        cycle();
        bus.dmem_ready = 0;
        repeat (3) begin
            #1 chk("frz_hold", bus.hold, 1);
            cycle();
            chk("frz_mdest", bus.mdestReg, 7);
            chk("frz_wwreg", bus.wwreg, 0);
        end
        bus.dmem_ready = 1;
        cycle();
        chk("frz_wdest", bus.wdestReg, 7);
        chk("frz_wwreg1", bus.wwreg, 1);
        cycle();
        chk("frz_once", bus.wwreg, 0);
`ifdef PIPE_CTRL_STATS_EN
        chk("frz_cnt", bus.freeze_cnt, 3);
`endif

        // Flush together with a load-use stall: a single bubble.
        do_reset();
        set_load(5'd1, 5'd5);
        cycle();
        set_rtype(5'd5, 5'd2, 5'd6);
        bus.flush = 1;
        #1 chk("fs_stall", bus.stall, 1);
        cycle();
        chk("fs_bubble", bus.edestReg, 0);
        bus.flush = 0;
        cycle();
        chk("fs_edest", bus.edestReg, 6);
        chk("fs_mdest", bus.mdestReg, 0);
        chk("fs_wdest", bus.wdestReg, 5);

        // Random traffic against the model, occasional mid-run reset.
        repeat (400) begin
            rand_inputs();
            rst = ($urandom_range(0, 49) == 0);
            cycle();
        end
        rst = 0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
